// File: rtl/alu_result_stage.sv
// Result stage after the 64-bit adder: NZCV derivation, flag register, B.cond evaluation,
// and a 2-entry skid buffer toward the memory stage. ALU_STAGE_PERF_EN adds a stall counter.
module alu_result_stage #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic             set_flags,
  input  logic             is_bcond,
  input  logic [3:0]       cond,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_nzcv,
  output logic             out_taken,
`ifdef ALU_STAGE_PERF_EN
  output logic [3:0]       flags_q,
  output logic [31:0]      perf_stall_cnt
`else
  output logic [3:0]       flags_q
`endif
);

  localparam int unsigned NZCV_W = 4;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0]  result;
    logic [NZCV_W-1:0] nzcv;
    logic              taken;
  } entry_t;

  state_t            r_state;
  state_t            w_state_nxt;
  entry_t            r_m;
  entry_t            r_k;
  entry_t            w_in_entry;
  logic              r_m_valid;
  logic              r_in_ready;
  logic [NZCV_W-1:0] r_flags;
  logic              w_accept;
  logic              w_load_m_in;
  logic              w_load_m_k;
  logic              w_load_k;
  logic              w_n;
  logic              w_z;
  logic              w_c;
  logic              w_v;
  logic              w_cond_true;
  logic              w_fn;
  logic              w_fz;
  logic              w_fc;
  logic              w_fv;

  assign w_accept = in_valid & r_in_ready;

  // Flags of the incoming adder result
  assign w_n = sum[WIDTH-1];
  assign w_z = (sum == '0);
  assign w_c = cout;
  assign w_v = (a_msb == b_msb) & (sum[WIDTH-1] != a_msb);

  // Branch condition is judged against the flags as they stood before this op
  assign {w_fn, w_fz, w_fc, w_fv} = r_flags;

  always_comb begin
    w_cond_true = 1'b1;
    case (cond)
      4'h0:    w_cond_true = w_fz;
      4'h1:    w_cond_true = ~w_fz;
      4'h2:    w_cond_true = w_fc;
      4'h3:    w_cond_true = ~w_fc;
      4'h4:    w_cond_true = w_fn;
      4'h5:    w_cond_true = ~w_fn;
      4'h6:    w_cond_true = w_fv;
      4'h7:    w_cond_true = ~w_fv;
      4'h8:    w_cond_true = w_fc & ~w_fz;
      4'h9:    w_cond_true = ~w_fc | w_fz;
      4'hA:    w_cond_true = (w_fn == w_fv);
      4'hB:    w_cond_true = (w_fn != w_fv);
      4'hC:    w_cond_true = ~w_fz & (w_fn == w_fv);
      4'hD:    w_cond_true = w_fz | (w_fn != w_fv);
      default: w_cond_true = 1'b1;
    endcase
  end

  assign w_in_entry.result = sum;
  assign w_in_entry.nzcv   = {w_n, w_z, w_c, w_v};
  assign w_in_entry.taken  = is_bcond & w_cond_true;

  // Skid-buffer next state and entry load controls
  always_comb begin
    w_state_nxt = r_state;
    w_load_m_in = 1'b0;
    w_load_m_k  = 1'b0;
    w_load_k    = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_load_m_in = 1'b1;
          w_state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (out_ready && w_accept) begin
          w_load_m_in = 1'b1;
        end else if (out_ready) begin
          w_state_nxt = ST_EMPTY;
        end else if (w_accept) begin
          w_load_k    = 1'b1;
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          w_load_m_k  = 1'b1;
          w_state_nxt = ST_ONE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_m_valid  <= 1'b0;
      r_in_ready <= 1'b0;
      r_m        <= '0;
      r_k        <= '0;
      r_flags    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_m_valid  <= (w_state_nxt != ST_EMPTY);
      r_in_ready <= (w_state_nxt != ST_FULL);
      if (w_load_m_in) begin
        r_m <= w_in_entry;
      end else if (w_load_m_k) begin
        r_m <= r_k;
      end
      if (w_load_k) begin
        r_k <= w_in_entry;
      end
      if (w_accept && set_flags && !is_bcond) begin
        r_flags <= w_in_entry.nzcv;
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_m_valid;
  assign out_result = r_m.result;
  assign out_nzcv   = r_m.nzcv;
  assign out_taken  = r_m.taken;
  assign flags_q    = r_flags;

`ifdef ALU_STAGE_PERF_EN
  logic [CNT_W-1:0] r_perf_cnt;

  // Saturating count of cycles where the producer was held off
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_cnt <= '0;
    end else if (in_valid && !r_in_ready && (r_perf_cnt != {CNT_W{1'b1}})) begin
      r_perf_cnt <= r_perf_cnt + CNT_W'(1);
    end
  end

  assign perf_stall_cnt = r_perf_cnt;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios then random traffic against a queue-based
// reference model. Define ALU_STAGE_PERF_EN to also cover the stall counter.
module tb_alu_result_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] sum;
  logic        cout;
  logic        a_msb;
  logic        b_msb;
  logic        set_flags;
  logic        is_bcond;
  logic [3:0]  cond;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [3:0]  out_nzcv;
  logic        out_taken;
  logic [3:0]  flags_q;
`ifdef ALU_STAGE_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  alu_result_stage #(.WIDTH(64)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .sum(sum),
    .cout(cout),
    .a_msb(a_msb),
    .b_msb(b_msb),
    .set_flags(set_flags),
    .is_bcond(is_bcond),
    .cond(cond),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_nzcv(out_nzcv),
    .out_taken(out_taken),
`ifdef ALU_STAGE_PERF_EN
    .flags_q(flags_q),
    .perf_stall_cnt(perf_stall_cnt)
`else
    .flags_q(flags_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic [3:0]  nzcv;
    logic        taken;
  } exp_t;

  exp_t        q[$];
  logic [3:0]  m_flags;
  logic        m_ready;
  logic [31:0] m_perf;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [3:0] flags_of(input logic [63:0] s, input logic c,
                                          input logic a, input logic b);
    logic n, z, v;
    n = s[63];
    z = (s == 64'd0);
    v = (a == b) && (s[63] != a);
    return {n, z, c, v};
  endfunction

  // ARM-style evaluation: base test from cond[3:1], odd codes invert (except AL)
  function automatic logic cond_holds(input logic [3:0] f, input logic [3:0] cc);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    case (cc[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (cc[0] && cc != 4'hF) return !base;
    return base;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] s, input logic c, input logic a,
                       input logic b, input logic sf, input logic bc, input logic [3:0] cc);
    in_valid  = v;
    sum       = s;
    cout      = c;
    a_msb     = a;
    b_msb     = b;
    set_flags = sf;
    is_bcond  = bc;
    cond      = cc;
  endtask

  // Compare DUT against model mid-cycle, advance model across the next edge, step one clock
  task automatic cycle();
    exp_t e;
    logic pop, push;
    @(negedge clk);
    chk("in_ready", 64'(in_ready), 64'(m_ready));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_result", out_result, q[0].res);
      chk("out_nzcv", 64'(out_nzcv), 64'(q[0].nzcv));
      chk("out_taken", 64'(out_taken), 64'(q[0].taken));
    end
    chk("flags_q", 64'(flags_q), 64'(m_flags));
`ifdef ALU_STAGE_PERF_EN
    chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'(m_perf));
`endif
    if (reset) begin
      q.delete();
      m_flags = 4'd0;
      m_ready = 1'b0;
      m_perf  = 32'd0;
    end else begin
      pop  = (q.size() > 0) && out_ready;
      push = in_valid && m_ready;
      if (in_valid && !m_ready && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
      e.res   = sum;
      e.nzcv  = flags_of(sum, cout, a_msb, b_msb);
      e.taken = is_bcond && cond_holds(m_flags, cond);
      if (push && set_flags && !is_bcond) m_flags = e.nzcv;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
      m_ready = (q.size() < 2);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    @(posedge clk);
    #1;
    q.delete();
    m_flags = 4'd0;
    m_ready = 1'b0;
    m_perf  = 32'd0;

    // Reset state
    cycle();
    reset = 1'b0;
    cycle();

    // ADDS with zero result
    drive(1'b1, 64'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    cycle();
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("adds_zero_valid", 64'(out_valid), 64'd1);
    chk("adds_zero_nzcv", 64'(out_nzcv), 64'h6);
    chk("adds_zero_flags", 64'(flags_q), 64'h6);
    cycle();

    // Signed overflow
    drive(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    cycle();
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("ovf_nzcv", 64'(out_nzcv), 64'h9);
    chk("ovf_flags", 64'(flags_q), 64'h9);

    // SUBS then B.cond EQ (taken) and LT (not taken); B.cond must not touch flags
    drive(1'b1, 64'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    cycle();
    drive(1'b1, 64'h8000_0000_0000_0005, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
    cycle();
    chk("beq_taken", 64'(out_taken), 64'd1);
    drive(1'b1, 64'h8000_0000_0000_0007, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hB);
    cycle();
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("blt_taken", 64'(out_taken), 64'd0);
    chk("bcond_flags", 64'(flags_q), 64'h6);
    cycle();

    // Back-pressure: 1, 2 accepted, 3 held until room
    out_ready = 1'b0;
    drive(1'b1, 64'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    cycle();
    drive(1'b1, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    cycle();
    drive(1'b1, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_hold1", out_result, 64'd1);
    cycle();
    cycle();
    chk("bp_still1", out_result, 64'd1);
    out_ready = 1'b1;
    cycle();
    chk("bp_out2", out_result, 64'd2);
    cycle();
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("bp_out3", out_result, 64'd3);
    cycle();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Reset while FULL with flags 1000
    out_ready = 1'b0;
    drive(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    cycle();
    drive(1'b1, 64'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    cycle();
    chk("rst_pre_flags", 64'(flags_q), 64'h8);
    chk("rst_pre_full", 64'(in_ready), 64'd0);
    reset     = 1'b1;
    out_ready = 1'b1;
    cycle();
    reset = 1'b0;
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    cycle();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_flags", 64'(flags_q), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    cycle();

`ifdef ALU_STAGE_PERF_EN
    // Stall counter: fill, then hold in_valid against FULL for 5 cycles
    out_ready = 1'b0;
    drive(1'b1, 64'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    cycle();
    cycle();
    for (int i = 0; i < 5; i++) cycle();
    chk("perf_five", 64'(perf_stall_cnt), 64'd5);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("perf_reset", 64'(perf_stall_cnt), 64'd0);
    cycle();
    out_ready = 1'b1;
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [63:0] s;
      s = {$urandom(), $urandom()};
      if ($urandom_range(7) == 0) s = 64'd0;
      drive(1'($urandom_range(3) != 0), s, 1'($urandom()), 1'($urandom()), 1'($urandom()),
            1'($urandom()), 1'($urandom_range(3) == 0), 4'($urandom()));
      out_ready = 1'($urandom_range(2) != 0);
      reset     = 1'($urandom_range(60) == 0);
      cycle();
    end
    reset = 1'b0;
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Pipeline stage directly downstream of the 64-bit carry-lookahead adder in the LEGv8 execute path.
- Captures the adder's sum and carry-out, derives the NZCV flags, and maintains the architectural flag register.
- Evaluates B.cond conditions and presents the registered result to the memory stage.
- Uses a 2-entry valid/ready skid buffer so downstream back-pressure never drops an adder result.

Parameters:
- WIDTH, 64, datapath width of sum/result; flag logic uses bit WIDTH-1 as sign.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  adder result valid this cycle
- in_ready  output  1  stage can accept; registered, not combinationally dependent on out_ready
- sum  input  WIDTH  adder S output
- cout  input  1  adder carry-out
- a_msb  input  1  MSB of adder operand A
- b_msb  input  1  MSB of adder operand B as presented to the adder (post-inversion for subtract)
- set_flags  input  1  op is ADDS/SUBS/ANDS-class; update flag register
- is_bcond  input  1  op is B.cond; evaluate cond
- cond  input  4  ARM condition code
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts
- out_result  output  WIDTH  registered sum
- out_nzcv  output  4  flags computed for this op {N,Z,C,V}
- out_taken  output  1  B.cond taken (0 for non-B.cond ops)
- flags_q  output  4  architectural NZCV register {N,Z,C,V}

Behaviour:
- Clock and reset: one clock `clk`; reset `reset` is synchronous, active-high.
- Reset values: out_valid=0, out_result=0, out_nzcv=0, out_taken=0, flags_q=0, skid entry empty.
  - in_ready=0 while reset is high; in_ready=1 on the first cycle after reset deasserts.
- Flag derivation (combinational on inputs):
  - N=sum[WIDTH-1]
  - Z=(sum==0)
  - C=cout
  - V=(a_msb==b_msb) & (sum[WIDTH-1]!=a_msb)
- Accept: in_valid & in_ready at a rising edge.
- Latency: 1 cycle from accept to out_valid when the output register is free.
- Flag register: flags_q <= computed NZCV on accept when set_flags=1 and is_bcond=0. Otherwise flags_q holds.
  - The update happens at accept time, not at output time, so the next accepted op evaluates against the new flags.
- Condition evaluation on accept, against flags_q before any same-edge update:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 HS: C
  - 3 LO: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 GT: !Z&(N==V)
  - 13 LE: Z|(N!=V)
  - 14/15: always true
  - taken = is_bcond & cond_true.
- Skid buffer. Entries are a main output register (M) and a skid register (K); each holds {result, nzcv, taken}.
  - State EMPTY (M empty, K empty): accept -> M, go to ONE.
  - State ONE (M full, K empty):
    - out_ready & accept -> M replaced, stay ONE.
    - out_ready & no accept -> EMPTY.
    - !out_ready & accept -> K, go to FULL.
  - State FULL (M full, K full): in_ready=0.
    - out_ready -> M<=K, K empty, go to ONE.
    - Input is ignored in FULL even if in_valid=1.
- in_ready = !K_valid (registered state).
- out_valid = M_valid. Output fields are stable while out_valid & !out_ready.
- Ordering: strict FIFO; no op is dropped or duplicated.
- Reset mid-operation: both entries are discarded and flags_q is cleared on the reset edge regardless of in_valid/out_ready.
- in_valid with in_ready=0: no state change; flags_q is not updated.

Optional Feature:
- Macro: ALU_STAGE_PERF_EN.
- Defined:
  - Adds output port perf_stall_cnt [31:0].
  - Increments each cycle with in_valid & !in_ready; saturates at 32'hFFFFFFFF.
  - Cleared by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- ADDS zero result: sum=0, cout=1, a_msb=1, b_msb=0, set_flags=1, out_ready=1 -> next cycle out_valid=1, out_result=0, out_nzcv=4'b0110, flags_q=4'b0110.
- Signed overflow: sum=64'h8000_0000_0000_0000, cout=0, a_msb=0, b_msb=0, set_flags=1 -> out_nzcv=4'b1001, flags_q=4'b1001.
- B.cond after SUBS: SUBS giving nzcv=4'b0110, then B.cond cond=4'h0 (EQ) next cycle -> out_taken=1; a second B.cond with cond=4'hB (LT) -> out_taken=0; flags_q unchanged by the B.cond ops.
- Back-pressure:
  - Stimulus: out_ready=0; accept ops with sums 1, 2, then hold in_valid with sum 3.
  - in_ready drops to 0 after the second accept; out_result holds 1.
  - Raise out_ready -> outputs 1, 2, 3 in order, each exactly once.
- Reset mid-flight: FULL state with flags_q=4'b1000, assert reset one cycle -> next cycle out_valid=0, flags_q=0, in_ready=1; no stale result ever appears.
- Perf counter (ALU_STAGE_PERF_EN): hold FULL with in_valid=1 for 5 cycles -> perf_stall_cnt=5; after reset -> 0.
